// File: rtl/frame_arb_pkg.sv
// Shared definitions for the frame round-robin arbiter.
//   - default parameter values for the arbiter top
//   - arbiter state encoding
//   - widths of the gap watchdog and the drop counter
package frame_arb_pkg;

    localparam int N_SRC_DEF   = 4;
    localparam int DW_DEF      = 8;
    localparam int GAP_MAX_DEF = 1023;

    localparam int GAP_W  = 10;
    localparam int DROP_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_e;

endpackage

// File: rtl/frame_rr_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req      : request vector, one bit per source
//   last_gnt : index of the most recently completed grant
//   win      : first requester found scanning upward from last_gnt+1, wrapping
//   req_any  : at least one request is present
module rr_pick #(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0]         req,
    input  logic [$clog2(N_SRC)-1:0] last_gnt,
    output logic [$clog2(N_SRC)-1:0] win,
    output logic                     req_any
);

    localparam int IW = $clog2(N_SRC);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        win     = '0;
        req_any = |req;
        found   = 1'b0;
        idx     = '0;
        // Offset 1 first, so the last winner only wins again when alone.
        for (int k = 1; k <= N_SRC; k++) begin
            idx = IW'((int'(last_gnt) + k) % N_SRC);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_rr_arbiter.sv
// Frame-aware round-robin arbiter: shares one downstream frame bus among
// N_SRC sources, locking the grant from sop to eop, with a registered output
// stage and a gap watchdog that terminates stalled frames.
//   clk, rst_n                          : clock, async active-low reset
//   src_data/src_sop/src_eop/src_vld    : per-source beat streams
//   src_rdy                             : per-source accept
//   dout/dout_sop/dout_eop/dout_vld     : registered output beat
//   dout_rdy                            : downstream accept
//   dout_err                            : beat is an abort or a mid-frame sop
//   gnt_idx                             : current or last grant
//   drop_cnt                            : saturating count of discarded beats
//
// state    | meaning
// ---------+---------------------------------------------
// ST_IDLE  | no source granted, arbitrating sop requests
// ST_XFER  | locked to gnt_idx until eop or gap timeout
// ST_ABORT | emitting the synthetic terminating beat
module frame_rr_arbiter
    import frame_arb_pkg::*;
#(
    parameter int N_SRC   = N_SRC_DEF,
    parameter int DW      = DW_DEF,
    parameter int GAP_MAX = GAP_MAX_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_SRC*DW-1:0]      src_data,
    input  logic [N_SRC-1:0]         src_sop,
    input  logic [N_SRC-1:0]         src_eop,
    input  logic [N_SRC-1:0]         src_vld,
    output logic [N_SRC-1:0]         src_rdy,
    output logic [DW-1:0]            dout,
    output logic                     dout_sop,
    output logic                     dout_eop,
    output logic                     dout_vld,
    input  logic                     dout_rdy,
    output logic                     dout_err,
    output logic [$clog2(N_SRC)-1:0] gnt_idx,
    output logic [DROP_W-1:0]        drop_cnt
);

    localparam int                IW      = $clog2(N_SRC);
    localparam logic [GAP_W-1:0]  GAP_LIM = GAP_W'(GAP_MAX);

    arb_state_e       state_q, state_d;
    logic [IW-1:0]    gnt_q, gnt_d;
    logic [IW-1:0]    last_gnt_q, last_gnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             first_q, first_d;
    logic [DW-1:0]    dout_q, dout_d;
    logic             dout_sop_q, dout_sop_d;
    logic             dout_eop_q, dout_eop_d;
    logic             dout_vld_q, dout_vld_d;
    logic             dout_err_q, dout_err_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic             out_rdy;
    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] gnt_oh;
    logic [N_SRC-1:0] disc;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    logic [DW-1:0]    sel_data;
    logic             sel_vld;
    logic             sel_sop;
    logic             sel_eop;
    logic             acc;
    logic [GAP_W-1:0] gap_inc;
    logic [DROP_W:0]  drop_sum;

    assign out_rdy = !dout_vld_q || dout_rdy;
    assign req     = src_vld & src_sop;

    rr_pick #(.N_SRC(N_SRC)) u_rr_pick (
        .req      (req),
        .last_gnt (last_gnt_q),
        .win      (pick_idx),
        .req_any  (pick_any)
    );

    always_comb begin
        sel_data = '0;
        sel_vld  = 1'b0;
        sel_sop  = 1'b0;
        sel_eop  = 1'b0;
        gnt_oh   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (IW'(i) == gnt_q) begin
                sel_data = src_data[i*DW +: DW];
                sel_vld  = src_vld[i];
                sel_sop  = src_sop[i];
                sel_eop  = src_eop[i];
                gnt_oh[i] = (state_q != ST_IDLE);
            end
        end
    end

    // Non-sop beats from sources that do not own the bus are swallowed so a
    // parser that lost sync cannot block the others; sop beats always wait.
    assign disc    = src_vld & ~src_sop & ~gnt_oh;
    assign src_rdy = disc | ((state_q == ST_XFER) ? (gnt_oh & {N_SRC{out_rdy}}) : '0);
    assign acc     = (state_q == ST_XFER) && sel_vld && out_rdy;
    assign gap_inc = gap_q + 1'b1;

    always_comb begin
        drop_sum = {1'b0, drop_q};
        for (int i = 0; i < N_SRC; i++) begin
            drop_sum = drop_sum + (DROP_W+1)'(disc[i]);
        end
        drop_d = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        gap_d      = gap_q;
        first_d    = first_q;
        dout_d     = dout_q;
        dout_sop_d = dout_sop_q;
        dout_eop_d = dout_eop_q;
        dout_vld_d = dout_vld_q;
        dout_err_d = dout_err_q;

        // Output register empties when drained and nothing new is loaded.
        if (out_rdy) begin
            dout_d     = '0;
            dout_sop_d = 1'b0;
            dout_eop_d = 1'b0;
            dout_vld_d = 1'b0;
            dout_err_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_idx;
                    gap_d   = '0;
                    first_d = 1'b1;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (acc) begin
                    dout_d     = sel_data;
                    dout_sop_d = sel_sop;
                    dout_eop_d = sel_eop;
                    dout_vld_d = 1'b1;
                    dout_err_d = sel_sop && !first_q;
                    first_d    = 1'b0;
                    gap_d      = '0;
                    if (sel_eop) begin
                        last_gnt_d = gnt_q;
                        state_d    = ST_IDLE;
                    end
                end else if (!sel_vld) begin
                    // Backpressure stalls with vld high do not count as a gap.
                    gap_d = gap_inc;
                    if (gap_inc == GAP_LIM) begin
                        state_d = ST_ABORT;
                    end
                end
            end
            ST_ABORT: begin
                if (out_rdy) begin
                    dout_d     = '0;
                    dout_sop_d = 1'b0;
                    dout_eop_d = 1'b1;
                    dout_vld_d = 1'b1;
                    dout_err_d = 1'b1;
                    last_gnt_d = gnt_q;
                    gap_d      = '0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            last_gnt_q <= IW'(N_SRC - 1);
            gap_q      <= '0;
            first_q    <= 1'b0;
            dout_q     <= '0;
            dout_sop_q <= 1'b0;
            dout_eop_q <= 1'b0;
            dout_vld_q <= 1'b0;
            dout_err_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            gap_q      <= gap_d;
            first_q    <= first_d;
            dout_q     <= dout_d;
            dout_sop_q <= dout_sop_d;
            dout_eop_q <= dout_eop_d;
            dout_vld_q <= dout_vld_d;
            dout_err_q <= dout_err_d;
            drop_q     <= drop_d;
        end
    end

    assign dout     = dout_q;
    assign dout_sop = dout_sop_q;
    assign dout_eop = dout_eop_q;
    assign dout_vld = dout_vld_q;
    assign dout_err = dout_err_q;
    assign gnt_idx  = gnt_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_frame_rr_arbiter.sv
// Directed bench for frame_rr_arbiter: per-source beat queues feed the DUT,
// a monitor logs every transferred output beat with its cycle stamp, and
// logged beats are compared against hand-written expected frames.
module tb_frame_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int GM = 1023;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N*DW-1:0]   src_data;
    logic [N-1:0]      src_sop, src_eop, src_vld, src_rdy;
    logic [DW-1:0]     dout;
    logic              dout_sop, dout_eop, dout_vld, dout_rdy, dout_err;
    logic [1:0]        gnt_idx;
    logic [15:0]       drop_cnt;

    int n_chk = 0;
    int n_err = 0;
    int cyc_cnt = 0;

    logic [9:0]  sq [N][$];   // {sop, eop, data}
    logic        rq [$];      // per-cycle dout_rdy plan, default 1
    logic [10:0] oq [$];      // {err, sop, eop, data}
    int          ts [$];
    logic [10:0] eq [$];

    always #5 clk = ~clk;

    frame_rr_arbiter #(.N_SRC(N), .DW(DW), .GAP_MAX(GM)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .src_data (src_data),
        .src_sop  (src_sop),
        .src_eop  (src_eop),
        .src_vld  (src_vld),
        .src_rdy  (src_rdy),
        .dout     (dout),
        .dout_sop (dout_sop),
        .dout_eop (dout_eop),
        .dout_vld (dout_vld),
        .dout_rdy (dout_rdy),
        .dout_err (dout_err),
        .gnt_idx  (gnt_idx),
        .drop_cnt (drop_cnt)
    );

    // Source driver: present queue heads on negedge, pop what will be accepted.
    initial begin
        logic [9:0] b;
        src_data = '0; src_sop = '0; src_eop = '0; src_vld = '0; dout_rdy = 1'b1;
        forever begin
            @(negedge clk);
            dout_rdy = (rq.size() > 0) ? rq.pop_front() : 1'b1;
            for (int i = 0; i < N; i++) begin
                if (sq[i].size() > 0) begin
                    b = sq[i][0];
                    src_vld[i] = 1'b1;
                    src_sop[i] = b[9];
                    src_eop[i] = b[8];
                    src_data[i*DW +: DW] = b[7:0];
                end else begin
                    src_vld[i] = 1'b0;
                    src_sop[i] = 1'b0;
                    src_eop[i] = 1'b0;
                    src_data[i*DW +: DW] = '0;
                end
            end
            #1;
            for (int i = 0; i < N; i++) begin
                if (src_vld[i] && src_rdy[i]) void'(sq[i].pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (rst_n && dout_vld && dout_rdy) begin
                oq.push_back({dout_err, dout_sop, dout_eop, dout});
                ts.push_back(cyc_cnt);
            end
            cyc_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    task automatic put(input int s, input logic sop, input logic eop, input logic [7:0] d);
        sq[s].push_back({sop, eop, d});
    endtask

    function automatic logic [10:0] ob(input logic e, input logic s, input logic p, input logic [7:0] d);
        return {e, s, p, d};
    endfunction

    task automatic clr();
        oq.delete(); ts.delete(); eq.delete();
    endtask

    task automatic drain(input string tag, input int budget);
        int  k;
        bit  busy;
        k = 0;
        busy = 1'b1;
        while (busy && k < budget) begin
            cyc();
            k++;
            busy = dout_vld;
            for (int i = 0; i < N; i++) if (sq[i].size() != 0) busy = 1'b1;
        end
        chk({tag, "_timeout"}, 32'(busy), 32'd0);
        repeat (4) cyc();
    endtask

    task automatic chk_out(input string tag);
        chk({tag, "_len"}, oq.size(), eq.size());
        for (int i = 0; i < eq.size() && i < oq.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), 32'(oq[i]), 32'(eq[i]));
    endtask

    initial begin
        int k;
        repeat (3) cyc();
        chk("rst_dout_vld", dout_vld, 0);
        chk("rst_dout",     dout, 0);
        chk("rst_flags",    {dout_sop, dout_eop, dout_err}, 0);
        chk("rst_src_rdy",  src_rdy, 0);
        chk("rst_gnt",      gnt_idx, 0);
        chk("rst_drop",     drop_cnt, 0);
        rst_n = 1'b1;
        cyc();

        // Single 4-beat frame on source 0, with grant/output latency.
        clr();
        put(0, 1, 0, 8'h55); put(0, 0, 0, 8'h01); put(0, 0, 0, 8'hAA); put(0, 0, 1, 8'hBB);
        cyc();
        chk("t1_sop_rdy_idle", src_rdy[0], 0);
        cyc();
        chk("t1_gnt",          gnt_idx, 0);
        chk("t1_rdy_xfer",     src_rdy[0], 1);
        chk("t1_vld_early",    dout_vld, 0);
        cyc();
        chk("t1_first_out",    {dout_vld, dout_sop, dout_eop, dout_err, dout}, {4'b1100, 8'h55});
        drain("t1", 50);
        eq.push_back(ob(0,1,0,8'h55)); eq.push_back(ob(0,0,0,8'h01));
        eq.push_back(ob(0,0,0,8'hAA)); eq.push_back(ob(0,0,1,8'hBB));
        chk_out("t1");

        // Fresh reset so source 0 has first priority again.
        rst_n = 1'b0;
        cyc();
        chk("rst2_gnt", gnt_idx, 0);
        chk("rst2_vld", dout_vld, 0);
        rst_n = 1'b1;
        cyc();

        // All four sources request at once: strict 0,1,2,3 with one idle cycle.
        clr();
        for (int s = 0; s < N; s++) begin
            put(s, 1, 0, 8'(16*s + 1)); put(s, 0, 0, 8'(16*s + 2)); put(s, 0, 1, 8'(16*s + 3));
        end
        drain("t2", 100);
        for (int s = 0; s < N; s++) begin
            eq.push_back(ob(0,1,0,8'(16*s + 1)));
            eq.push_back(ob(0,0,0,8'(16*s + 2)));
            eq.push_back(ob(0,0,1,8'(16*s + 3)));
        end
        chk_out("t2");
        if (ts.size() == 12) begin
            for (int f = 1; f < N; f++)
                chk($sformatf("t2_gap%0d", f), ts[3*f] - ts[3*f-1], 2);
            chk("t2_burst", ts[2] - ts[0], 2);
        end else begin
            chk("t2_ts_len", ts.size(), 12);
        end

        // Backpressure 1,0,0,1 mid-frame: output holds, nothing lost.
        clr();
        put(0, 1, 0, 8'h30); put(0, 0, 0, 8'h31); put(0, 0, 0, 8'h32); put(0, 0, 1, 8'h33);
        rq.push_back(1); rq.push_back(1); rq.push_back(1);
        rq.push_back(0); rq.push_back(0); rq.push_back(1);
        repeat (4) cyc();
        chk("t3_hold0", {dout_vld, dout_sop, dout_eop, dout}, {3'b100, 8'h31});
        chk("t3_src_stall", src_rdy[0], 0);
        cyc();
        chk("t3_hold1", {dout_vld, dout_sop, dout_eop, dout}, {3'b100, 8'h31});
        cyc();
        chk("t3_hold2", {dout_vld, dout_sop, dout_eop, dout}, {3'b100, 8'h31});
        drain("t3", 50);
        eq.push_back(ob(0,1,0,8'h30)); eq.push_back(ob(0,0,0,8'h31));
        eq.push_back(ob(0,0,0,8'h32)); eq.push_back(ob(0,0,1,8'h33));
        chk_out("t3");

        // Source 2 stalls after its sop beat; watchdog aborts, source 3 follows.
        clr();
        put(2, 1, 0, 8'h22);
        repeat (10) cyc();
        put(3, 1, 0, 8'h40); put(3, 0, 0, 8'h41); put(3, 0, 1, 8'h42);
        cyc();
        chk("t4_gnt2", gnt_idx, 2);
        chk("t4_src3_wait", src_rdy[3], 0);
        k = 0;
        while (sq[3].size() != 0 && k < 1200) begin
            cyc();
            k++;
        end
        chk("t4_timeout", 32'(sq[3].size()), 0);
        repeat (4) cyc();
        eq.push_back(ob(0,1,0,8'h22)); eq.push_back(ob(1,0,1,8'h00));
        eq.push_back(ob(0,1,0,8'h40)); eq.push_back(ob(0,0,0,8'h41)); eq.push_back(ob(0,0,1,8'h42));
        chk_out("t4");
        if (ts.size() == 5) begin
            chk("t4_abort_time", ts[1] - ts[0], GM + 1);
            chk("t4_regrant",    ts[2] - ts[1], 2);
        end else begin
            chk("t4_ts_len", ts.size(), 5);
        end
        chk("t4_gnt3", gnt_idx, 3);

        // Source 1 sends five non-sop beats while idle: all dropped.
        clr();
        chk("t5_drop0", drop_cnt, 0);
        for (int i = 0; i < 5; i++) put(1, 0, 0, 8'(8'hD0 + i));
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("t5_rdy%0d", i), src_rdy[1], 1);
        end
        repeat (3) cyc();
        chk("t5_drop5", drop_cnt, 5);
        chk("t5_no_out", oq.size(), 0);

        // Single-beat frame, then a frame with a mid-frame sop.
        clr();
        put(0, 1, 1, 8'h61);
        put(0, 1, 0, 8'h71); put(0, 0, 0, 8'h72); put(0, 1, 0, 8'h73); put(0, 0, 1, 8'h74);
        drain("t6", 60);
        eq.push_back(ob(0,1,1,8'h61)); eq.push_back(ob(0,1,0,8'h71));
        eq.push_back(ob(0,0,0,8'h72)); eq.push_back(ob(1,1,0,8'h73)); eq.push_back(ob(0,0,1,8'h74));
        chk_out("t6");
        if (ts.size() == 5) chk("t6_gap", ts[1] - ts[0], 2);
        else                chk("t6_ts_len", ts.size(), 5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/frame_rr_arbiter.md
# frame_rr_arbiter

Frame-aware round-robin arbiter that shares one downstream frame bus among `N_SRC` frame parsers. Each source emits `data/sop/eop/vld` streams with HEAD/TYPE/LEN/DATA/FCS payloads already framed. The arbiter locks its grant from `sop` to `eop`, so frames are never interleaved. A registered output stage provides `dout_rdy` backpressure. A gap watchdog aborts frames whose source stalls.

## Interface
- `N_SRC`, default 4: number of requesting sources (2..8).
- `DW`, default 8: data width per beat.
- `GAP_MAX`, default 1023: idle cycles tolerated inside a frame before abort.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `src_data`  in  N_SRC*DW  packed source data; source i at `[i*DW +: DW]`.
- `src_sop`  in  N_SRC  first beat of frame.
- `src_eop`  in  N_SRC  last beat of frame.
- `src_vld`  in  N_SRC  beat valid.
- `src_rdy`  out  N_SRC  beat accepted when `src_vld[i] & src_rdy[i]`.
- `dout`  out  DW  forwarded data.
- `dout_sop`  out  1  first beat.
- `dout_eop`  out  1  last beat.
- `dout_vld`  out  1  output beat valid.
- `dout_rdy`  in  1  downstream accepts beat.
- `dout_err`  out  1  qualifies the current beat as erroneous (abort or mid-frame sop).
- `gnt_idx`  out  clog2(N_SRC)  current or last grant.
- `drop_cnt`  out  16  saturating count of discarded out-of-frame beats.

## Operation
- Output register `out_rdy = !dout_vld | dout_rdy`. The register loads only when `out_rdy` is high. Otherwise it holds all `dout*` signals stable.
- States:
  - IDLE: no source is granted.
  - XFER: locked to `gnt_idx`.
  - ABORT: emitting the synthetic terminating beat.
- IDLE:
  - A request is `src_vld[i] & src_sop[i]`.
  - The winner is the first requester scanning upward from `last_gnt+1`, wrapping modulo N_SRC.
  - On any request, register `gnt_idx` and move to XFER.
  - All `src_rdy` are 0 for sop beats.
  - Beats with `src_vld` high and `src_sop` low on any non-granted source are discarded with `src_rdy=1`, and `drop_cnt` increments once per discarded beat.
- XFER:
  - `src_rdy[gnt] = out_rdy`. Other sources follow the discard rule above.
  - Accepted beats are copied unchanged to `dout*`.
  - An accepted beat with `eop` sets `last_gnt = gnt` and moves to IDLE. This includes a beat with both sop and eop (a single-beat frame).
  - A beat with `sop` that is not the first beat of the frame is forwarded with `dout_err=1`. The frame continues.
- Gap watchdog:
  - The 10-bit counter clears on every accepted beat and increments while `src_vld[gnt]` is 0 in XFER.
  - When it reaches `GAP_MAX`, the state moves to ABORT.
- ABORT:
  - When `out_rdy` is high, emit one beat: `dout=0`, `dout_eop=1`, `dout_err=1`, `dout_vld=1`.
  - Then set `last_gnt = gnt` and move to IDLE.
  - `src_rdy[gnt]=0` while in ABORT.
- `drop_cnt` saturates at 16'hFFFF.

## Timing
- Reset values:
  - State IDLE.
  - `dout` 0, `dout_sop` 0, `dout_eop` 0, `dout_vld` 0, `dout_err` 0.
  - `src_rdy` 0.
  - `gnt_idx` 0; `last_gnt` = N_SRC-1, so source 0 has first priority.
  - `drop_cnt` 0, gap counter 0.
- Reset mid-frame aborts silently; no eop is generated.
- Grant latency:
  - sop presented in IDLE at cycle T → grant registered at T+1.
  - Beat accepted at T+1 if `out_rdy` → `dout_vld` at T+2.
- Steady state: one beat per cycle while `dout_rdy=1`. Throughput is unaffected by the output register.
- Frame-to-frame: at least 1 idle cycle (the IDLE arbitration cycle) between the `eop` acceptance and the next `sop` acceptance.
- Simultaneous requests are resolved purely by the round-robin pointer. The pointer advances only on frame completion or abort.
- `dout_rdy` low for any duration holds the output without loss and does not advance the gap counter, because the source is stalled by `src_rdy`.

## Structure
- Package `frame_arb_pkg`:
  - State enum (IDLE/XFER/ABORT).
  - Default `DW`, `N_SRC`, `GAP_MAX`.
  - Gap counter width constant.
- Sub-module `rr_pick`: combinational round-robin picker. Inputs are the request vector and `last_gnt`; outputs are the winner index and an any-request flag.
- The top level holds the FSM, gap counter, output register and `drop_cnt`.

## Test plan
- Single source 0, 4-beat frame 0x55,0x01,0xAA,0xBB with eop on the last beat, `dout_rdy=1` → `dout` shows the same 4 beats starting 2 cycles after sop, sop/eop on the first/last beat, `dout_err=0`.
- Sources 0..3 all hold sop simultaneously, 3-beat frames → output order 0,1,2,3, no interleaving, with 1 idle cycle between frames.
- `dout_rdy` toggling 1,0,0,1 during a frame → no lost or duplicated beats, and `dout*` stable while stalled.
- Source 2 granted, then `src_vld` low for 1023 cycles → ABORT beat `dout=0x00` with eop=1 and err=1, followed by grant to the next requester (source 3).
- Source 1 sends 5 beats without sop while idle → `src_rdy[1]=1` on each, `drop_cnt=5`, no output.
- Single-beat frame with sop=eop=1, followed by a mid-frame sop in the next frame → the first frame completes in 1 beat; the mid-frame sop beat is forwarded with `dout_err=1`.
